// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into 32-bit words
// and writes NMEM of them to consecutive word addresses while holding the CPU.
module imem_loader #(
   parameter int NMEM  = 15,
   parameter int DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [6:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        busy,
   output logic        done
);

   // One extra counter bit so a full DEPTH-word session ends without wrapping to 0.
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NMEM);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_r;
   logic [CW-1:0]   word_cnt_r;
   logic [1:0]      byte_cnt_r;
   logic [31:0]     shift_r;
   logic [4:0]      outs_r;

   // Output vector {byte_ready, mem_we, busy, done, cpu_hold} for each state.
   function automatic logic [4:0] outs_of(input state_t s);
      logic [4:0] o;
      case (s)
         IDLE:    o = 5'b00001;
         RECV:    o = 5'b10101;
         WRITE:   o = 5'b01101;
         DONE:    o = 5'b00010;
         default: o = 5'b00001;
      endcase
      return o;
   endfunction

   // Loader FSM; outputs are registered together with the state they belong to.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         word_cnt_r <= '0;
         byte_cnt_r <= 2'd0;
         shift_r    <= 32'd0;
         outs_r     <= outs_of(IDLE);
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  state_r    <= RECV;
                  word_cnt_r <= '0;
                  byte_cnt_r <= 2'd0;
                  outs_r     <= outs_of(RECV);
               end
            end
            RECV: begin
               if (byte_valid) begin
                  shift_r    <= {shift_r[23:0], byte_data};
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     state_r <= WRITE;
                     outs_r  <= outs_of(WRITE);
                  end
               end
            end
            WRITE: begin
               word_cnt_r <= word_cnt_r + ONE_CNT;
               if ((word_cnt_r + ONE_CNT) == LAST_CNT) begin
                  state_r <= DONE;
                  outs_r  <= outs_of(DONE);
               end else begin
                  state_r <= RECV;
                  outs_r  <= outs_of(RECV);
               end
            end
            default: begin
               state_r <= IDLE;
               outs_r  <= outs_of(IDLE);
            end
         endcase
      end
   end

   assign {byte_ready, mem_we, busy, done, cpu_hold} = outs_r;
   assign mem_addr  = word_cnt_r[6:0];
   assign mem_wdata = shift_r;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: one instance with NMEM=15, one with NMEM=128,
// driven by random byte streams with a word-level reference model.
module tb_imem_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       byte_valid = 1'b0;
   logic [7:0] byte_data = 8'd0;
   logic       sel = 1'b0;

   logic start_a, bv_a, start_b, bv_b;
   assign start_a = start & ~sel;
   assign bv_a    = byte_valid & ~sel;
   assign start_b = start & sel;
   assign bv_b    = byte_valid & sel;

   logic        byte_ready_a, mem_we_a, cpu_hold_a, busy_a, done_a;
   logic [6:0]  mem_addr_a;
   logic [31:0] mem_wdata_a;
   logic        byte_ready_b, mem_we_b, cpu_hold_b, busy_b, done_b;
   logic [6:0]  mem_addr_b;
   logic [31:0] mem_wdata_b;

   imem_loader #(.NMEM(15), .DEPTH(128)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .byte_valid(bv_a), .byte_data(byte_data),
      .byte_ready(byte_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
      .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a), .busy(busy_a), .done(done_a));

   imem_loader #(.NMEM(128), .DEPTH(128)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .byte_valid(bv_b), .byte_data(byte_data),
      .byte_ready(byte_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b), .busy(busy_b), .done(done_b));

   logic sel_ready, sel_we, sel_hold, sel_busy, sel_done;
   assign sel_ready = sel ? byte_ready_b : byte_ready_a;
   assign sel_we    = sel ? mem_we_b     : mem_we_a;
   assign sel_hold  = sel ? cpu_hold_b   : cpu_hold_a;
   assign sel_busy  = sel ? busy_b       : busy_a;
   assign sel_done  = sel ? done_b       : done_a;

   typedef struct packed {
      logic [6:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_a[$];
   wr_t        exp_b[$];
   logic [7:0] stream[$];
   logic [31:0] memimg_a [0:127];

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_total++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h want %h", name, got, want);
   endtask

   function automatic logic [31:0] word_of(input int w);
      return {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
   endfunction

   // Monitor for the NMEM=15 instance: every write must match the next expected word.
   always @(negedge clk) begin
      if (mem_we_a) begin
         memimg_a[mem_addr_a] = mem_wdata_a;
         if (exp_a.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write_a: got addr %0d data %h want no write", mem_addr_a, mem_wdata_a);
         end else begin
            wr_t e;
            e = exp_a.pop_front();
            check("write_a", 64'({mem_addr_a, mem_wdata_a, byte_ready_a, busy_a, cpu_hold_a}),
                  64'({e.addr, e.data, 1'b0, 1'b1, 1'b1}));
         end
      end
   end

   // Monitor for the NMEM=128 instance.
   always @(negedge clk) begin
      if (mem_we_b) begin
         if (exp_b.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write_b: got addr %0d data %h want no write", mem_addr_b, mem_wdata_b);
         end else begin
            wr_t e;
            e = exp_b.pop_front();
            check("write_b", 64'({mem_addr_b, mem_wdata_b, byte_ready_b, busy_b, cpu_hold_b}),
                  64'({e.addr, e.data, 1'b0, 1'b1, 1'b1}));
         end
      end
   end

   task automatic check_reset();
      check("reset_a", 64'({byte_ready_a, mem_we_a, mem_addr_a, mem_wdata_a, busy_a, done_a, cpu_hold_a}),
            64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1}));
      check("reset_b", 64'({byte_ready_b, mem_we_b, mem_addr_b, mem_wdata_b, busy_b, done_b, cpu_hold_b}),
            64'({1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b1}));
   endtask

   // Reset with start and byte_valid also high: reset must win.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; start = 1'b1; byte_valid = 1'b1;
      @(negedge clk);
      check_reset();
      rst_n = 1'b1; start = 1'b0; byte_valid = 1'b0;
   endtask

   task automatic build(input int nwords, input int npush);
      wr_t e;
      stream.delete();
      for (int i = 0; i < 4 * nwords; i++) stream.push_back(8'($urandom));
      for (int w = 0; w < npush; w++) begin
         e.addr = 7'(w);
         e.data = word_of(w);
         if (sel) exp_b.push_back(e);
         else     exp_a.push_back(e);
      end
   endtask

   task automatic kick();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("recv_flags", 64'({sel_hold, sel_busy, sel_ready, sel_done}), 64'({1'b1, 1'b1, 1'b1, 1'b0}));
   endtask

   task automatic send(input int nbytes, input bit rnd, input bit poke);
      int idx = 0;
      int budget = 0;
      bit pend = 1'b0;
      bit hs;
      while (idx < nbytes && budget < 20000) begin
         @(negedge clk);
         budget++;
         if (pend) begin
            check("we_latency", 64'(sel_we), 64'(1));
            pend = 1'b0;
         end
         byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         byte_data  = stream[idx];
         start      = (poke && $urandom_range(0, 5) == 0) ? 1'b1 : 1'b0;
         hs = byte_valid && sel_ready;
         @(posedge clk);
         if (hs) begin
            if (idx % 4 == 3) pend = 1'b1;
            idx++;
         end
      end
      @(negedge clk);
      byte_valid = 1'b0; start = 1'b0;
      if (pend) check("we_latency", 64'(sel_we), 64'(1));
      if (idx < nbytes) begin
         n_total++;
         $display("FAIL send_timeout: got %0d bytes want %0d", idx, nbytes);
      end
   endtask

   task automatic finish_session();
      for (int k = 0; k < 20 && !sel_done; k++) @(negedge clk);
      check("done_flags", 64'({sel_done, sel_hold, sel_busy, sel_ready}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
      check("writes_seen", 64'(sel ? exp_b.size() : exp_a.size()), 64'(0));
   endtask

   task automatic run(input int nw, input bit rnd, input bit poke);
      build(nw, nw);
      kick();
      send(4 * nw, rnd, poke);
      finish_session();
   endtask

   task automatic readback_a();
      for (int w = 0; w < 15; w++) check("readback_a", 64'(memimg_a[w]), 64'(word_of(w)));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0;
      do_reset();

      // Single hand-picked word: 8C 01 00 04 lands at address 0.
      stream.delete();
      stream.push_back(8'h8C); stream.push_back(8'h01);
      stream.push_back(8'h00); stream.push_back(8'h04);
      exp_a.push_back('{addr: 7'd0, data: 32'h8C010004});
      kick();
      send(4, 1'b0, 1'b0);
      @(negedge clk);
      check("after_first_word", 64'({byte_ready_a, mem_addr_a, done_a}), 64'({1'b1, 7'd1, 1'b0}));
      check("first_word_seen", 64'(exp_a.size()), 64'(0));

      // Full back-to-back session.
      do_reset();
      run(15, 1'b0, 1'b0);
      readback_a();

      // byte_valid pulses while DONE must not write.
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         byte_valid = 1'($urandom_range(0, 1));
         byte_data  = 8'($urandom);
      end
      @(negedge clk); byte_valid = 1'b0;
      check("done_holds", 64'({done_a, cpu_hold_a, mem_addr_a}), 64'({1'b1, 1'b0, 7'd15}));

      // Reload from DONE with random valid and stray start pulses.
      run(15, 1'b1, 1'b1);
      readback_a();

      // Reset two bytes into word 3 discards it; restart reloads from address 0.
      kick();
      build(15, 3);
      send(14, 1'b1, 1'b0);
      do_reset();
      repeat (8) @(negedge clk);
      check("abort_no_write", 64'(exp_a.size()), 64'(0));
      run(15, 1'b1, 1'b0);
      readback_a();

      // Full-depth session on the NMEM=128 instance.
      sel = 1'b1;
      run(128, 1'b1, 1'b1);
      repeat (10) @(negedge clk);
      check("b_stays_done", 64'({done_b, mem_we_b}), 64'({1'b1, 1'b0}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter NMEM, default 15, is the number of 32-bit words loaded per session, legal range 1..128.
REQ-002 Parameter DEPTH, default 128, is the number of instruction-memory word entries.
REQ-003 Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start  input  1  single-cycle request to begin a load session.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  incoming instruction byte, most-significant byte of each word first.
REQ-009 byte_ready  output  1  loader accepts byte_data this cycle.
REQ-010 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-011 mem_addr  output  7  word index into instruction memory, same indexing as pc[8:2].
REQ-012 mem_wdata  output  32  assembled instruction word.
REQ-013 cpu_hold  output  1  holds the CPU (PC and fetch) while memory is being written.
REQ-014 busy  output  1  load session in progress.
REQ-015 done  output  1  NMEM words written; CPU released.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: byte_ready=0, mem_we=0, busy=0; start=1 -> RECV next cycle, with word counter=0 and byte counter=0.
REQ-018 RECV: byte_ready=1, busy=1; a byte transfers only on a cycle with byte_valid=1 and byte_ready=1.
REQ-019 On each transfer: shift register <= {shift[23:0], byte_data}; byte counter increments mod 4.
REQ-020 Fourth transfer of a word -> WRITE next cycle; the shift register then holds bytes b0..b3 as {b0,b1,b2,b3}.
REQ-021 WRITE lasts exactly one cycle: mem_we=1, mem_wdata=shift register, mem_addr=word counter, byte_ready=0.
REQ-022 Leaving WRITE, the word counter increments; if the new count equals NMEM -> DONE, else -> RECV.
REQ-023 mem_addr equals the word counter in all states, so words land at indices 0..NMEM-1 in order.
REQ-024 Latency: mem_we asserts on the cycle immediately after the 4th byte handshake; minimum 5 cycles per word.
REQ-025 DONE: done=1, cpu_hold=0, busy=0, byte_ready=0; the FSM stays in DONE until start.
REQ-026 start in DONE -> RECV with counters cleared and cpu_hold=1 from the next cycle (reload).
REQ-027 start in RECV or WRITE is ignored; it neither restarts the session nor corrupts the partial word.
REQ-028 byte_valid is ignored in IDLE, WRITE and DONE: no transfer, no counter change.
REQ-029 byte_valid held low in RECV stalls indefinitely with no state change.
REQ-030 cpu_hold=1 in IDLE, RECV and WRITE; cpu_hold=0 only in DONE.
REQ-031 mem_we is never asserted outside WRITE; at most NMEM writes occur per session.
REQ-032 With NMEM=DEPTH=128, the last write is at address 127; the word counter never wraps to address 0 within a session.

Reset
REQ-033 When rst_n=0 at a clock edge: state=IDLE, word and byte counters=0, shift register=0.
REQ-034 Outputs after that edge: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, cpu_hold=1.
REQ-035 Reset mid-session (RECV or WRITE) aborts the session; a partial word is discarded, and no mem_we pulse follows the reset cycle.
REQ-036 rst_n has priority over start and byte_valid on the same edge.

Verification
REQ-037 Reset, then start; bytes 8C,01,00,04 with valid held high -> one mem_we pulse, addr 0, wdata 32'h8C010004, the cycle after the 4th byte.
REQ-038 NMEM=15, 60 back-to-back bytes -> 15 writes at addr 0..14, then done=1 and cpu_hold=0; readback of memory matches the stream.
REQ-039 byte_valid toggled randomly; start pulsed during RECV -> identical memory contents and write count as the back-to-back case; start has no effect.
REQ-040 rst_n=0 after 2 bytes of word 3 -> outputs at reset values; no write at addr 3; a new start reloads from addr 0.
REQ-041 NMEM=128 -> the last write is at addr 127 with wdata equal to the final 4 bytes, then DONE; no write to addr 0 after.
REQ-042 In DONE, byte_valid pulses produce no writes; start then reloads, with cpu_hold=1 until the new NMEM words are written.
